// File: rtl/lcd_box_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_box_renderer_pkg
// Brief    : Shared types and constants for the bouncing-box pixel source:
//            RGB565 field widths, colour constants, panel geometry defaults,
//            axis direction encoding and span/edge helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_box_renderer_pkg;

  // RGB565 field widths
  localparam int c_R_W = 5;
  localparam int c_G_W = 6;
  localparam int c_B_W = 5;

  // Pixel coordinates arrive as 11 bits; all box arithmetic runs in 12 bits
  // so that sums like pos + SIZE + STEP can never wrap.
  localparam int c_POS_W   = 11;
  localparam int c_ARITH_W = 12;

  typedef struct packed {
    logic [c_R_W-1:0] r;
    logic [c_G_W-1:0] g;
    logic [c_B_W-1:0] b;
  } rgb565_t;

  localparam rgb565_t c_COL_BLACK   = '{r: 5'd0,  g: 6'd0,  b: 5'd0};
  localparam rgb565_t c_COL_WHITE   = '{r: 5'd31, g: 6'd63, b: 5'd31};
  localparam rgb565_t c_COL_FILL    = '{r: 5'd31, g: 6'd0,  b: 5'd0};
  localparam rgb565_t c_COL_BG_DARK = '{r: 5'd4,  g: 6'd8,  b: 5'd4};

  // Panel geometry defaults
  localparam int c_LCD_480_272_H = 480;
  localparam int c_LCD_480_272_V = 272;
  localparam int c_LCD_800_480_H = 800;
  localparam int c_LCD_800_480_V = 480;

  // Direction of travel along one axis
  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  // True when lo <= v < lo + size
  function automatic logic in_span(input logic [c_ARITH_W-1:0] v,
                                   input logic [c_ARITH_W-1:0] lo,
                                   input logic [c_ARITH_W-1:0] size);
    return (v >= lo) && (v < (lo + size));
  endfunction

  // True when v lies within 'thick' of either end of [lo, lo+size-1];
  // only meaningful when v is already inside the span.
  function automatic logic near_edge(input logic [c_ARITH_W-1:0] v,
                                     input logic [c_ARITH_W-1:0] lo,
                                     input logic [c_ARITH_W-1:0] size,
                                     input logic [c_ARITH_W-1:0] thick);
    return ((v - lo) < thick) || ((lo + size - 12'd1 - v) < thick);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_box_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_box_renderer_if
// Brief    : Timing-in / pixel-out bundle between lcd_driver, the box
//            renderer and the LCD colour pins.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_box_renderer_if;
  import lcd_box_renderer_pkg::*;

  logic               ENABLE;
  logic               HSYNC_IN;
  logic               VSYNC_IN;
  logic               DEN_IN;
  logic [c_POS_W-1:0] XPOS;
  logic [c_POS_W-1:0] YPOS;

  logic               HSYNC_OUT;
  logic               VSYNC_OUT;
  logic               DEN_OUT;
  logic [c_R_W-1:0]   LCD_R;
  logic [c_G_W-1:0]   LCD_G;
  logic [c_B_W-1:0]   LCD_B;
  logic               FRAME_TICK;

  // Timing source / pixel sink side
  modport master (
    output ENABLE, HSYNC_IN, VSYNC_IN, DEN_IN, XPOS, YPOS,
    input  HSYNC_OUT, VSYNC_OUT, DEN_OUT, LCD_R, LCD_G, LCD_B, FRAME_TICK
  );

  // Renderer side
  modport slave (
    input  ENABLE, HSYNC_IN, VSYNC_IN, DEN_IN, XPOS, YPOS,
    output HSYNC_OUT, VSYNC_OUT, DEN_OUT, LCD_R, LCD_G, LCD_B, FRAME_TICK
  );

endinterface
`default_nettype wire

// File: rtl/lcd_box_renderer_box_axis_motion.sv
`default_nettype none
// ============================================================================
// Module   : box_axis_motion
// Brief    : Position and direction of the box along one axis. Moves STEP
//            pixels per frame start while enabled and bounces off both ends
//            of the active area. At an edge the box dwells for one frame:
//            the position clamps and only the direction flips.
// Revision : 1.0 - initial release
// ============================================================================
module box_axis_motion
  import lcd_box_renderer_pkg::*;
#(
  parameter int ACTIVE = 480,
  parameter int SIZE   = 64,
  parameter int STEP   = 1
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_frame_start,
  input  wire logic                 i_enable,
  output logic      [c_ARITH_W-1:0] o_pos
);

  localparam logic [c_ARITH_W-1:0] c_ACTIVE = c_ARITH_W'(ACTIVE);
  localparam logic [c_ARITH_W-1:0] c_SIZE   = c_ARITH_W'(SIZE);
  localparam logic [c_ARITH_W-1:0] c_STEP   = c_ARITH_W'(STEP);
  localparam logic [c_ARITH_W-1:0] c_LIMIT  = c_ARITH_W'(ACTIVE - SIZE);

  logic [c_ARITH_W-1:0] r_pos;
  logic [c_ARITH_W-1:0] w_pos_nxt;
  dir_t                 r_dir;
  dir_t                 w_dir_nxt;

  // Bounce rule: next position/direction, held unless a frame starts while enabled
  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    if (i_frame_start && i_enable) begin
      case (r_dir)
        DIR_POS: begin
          if ((r_pos + c_SIZE + c_STEP) > c_ACTIVE) begin
            w_pos_nxt = c_LIMIT;
            w_dir_nxt = DIR_NEG;
          end else begin
            w_pos_nxt = r_pos + c_STEP;
          end
        end
        DIR_NEG: begin
          if (r_pos < c_STEP) begin
            w_pos_nxt = '0;
            w_dir_nxt = DIR_POS;
          end else begin
            w_pos_nxt = r_pos - c_STEP;
          end
        end
        default: begin
          w_pos_nxt = '0;
          w_dir_nxt = DIR_POS;
        end
      endcase
    end
  end

  // Position/direction state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos <= '0;
      r_dir <= DIR_POS;
    end else begin
      r_pos <= w_pos_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  assign o_pos = r_pos;

endmodule
`default_nettype wire

// File: rtl/lcd_box_renderer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_box_renderer
// Brief    : Pixel source fed by lcd_driver timing. Draws a bordered box
//            bouncing over a checkerboard and outputs registered RGB565 with
//            sync/enable delayed by the same two cycles. The box moves once
//            per frame at the VSYNC falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_box_renderer
  import lcd_box_renderer_pkg::*;
#(
  parameter int H_ACTIVE = c_LCD_480_272_H,
  parameter int V_ACTIVE = c_LCD_480_272_V,
  parameter int BOX_W    = 64,
  parameter int BOX_H    = 48,
  parameter int STEP     = 1,
  parameter int BORDER   = 2
) (
  input wire logic           PIXEL_CLK,
  input wire logic           RESET,
  lcd_box_renderer_if.slave  bus
);

  localparam logic [c_ARITH_W-1:0] c_BOX_W  = c_ARITH_W'(BOX_W);
  localparam logic [c_ARITH_W-1:0] c_BOX_H  = c_ARITH_W'(BOX_H);
  localparam logic [c_ARITH_W-1:0] c_BORDER = c_ARITH_W'(BORDER);

  // Frame detect
  logic r_vsync_d;
  logic r_frame_tick;
  logic w_frame_start;

  // Box position
  logic [c_ARITH_W-1:0] w_box_x;
  logic [c_ARITH_W-1:0] w_box_y;

  // Stage 1 combinational classification
  logic [c_ARITH_W-1:0] w_x;
  logic [c_ARITH_W-1:0] w_y;
  logic                 w_inside;
  logic                 w_border;
  logic                 w_checker;

  // Stage 1 registers
  logic r_s1_hsync;
  logic r_s1_vsync;
  logic r_s1_den;
  logic r_s1_inside;
  logic r_s1_border;
  logic r_s1_checker;

  // Stage 2 registers
  rgb565_t w_rgb;
  rgb565_t r_s2_rgb;
  logic    r_s2_hsync;
  logic    r_s2_vsync;
  logic    r_s2_den;

  assign w_frame_start = r_vsync_d & ~bus.VSYNC_IN;

  // VSYNC edge history and the one-cycle frame tick
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      r_vsync_d    <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_vsync_d    <= bus.VSYNC_IN;
      r_frame_tick <= w_frame_start;
    end
  end

  box_axis_motion #(
    .ACTIVE (H_ACTIVE),
    .SIZE   (BOX_W),
    .STEP   (STEP)
  ) u_axis_x (
    .clk           (PIXEL_CLK),
    .rst           (RESET),
    .i_frame_start (w_frame_start),
    .i_enable      (bus.ENABLE),
    .o_pos         (w_box_x)
  );

  box_axis_motion #(
    .ACTIVE (V_ACTIVE),
    .SIZE   (BOX_H),
    .STEP   (STEP)
  ) u_axis_y (
    .clk           (PIXEL_CLK),
    .rst           (RESET),
    .i_frame_start (w_frame_start),
    .i_enable      (bus.ENABLE),
    .o_pos         (w_box_y)
  );

  assign w_x = {1'b0, bus.XPOS};
  assign w_y = {1'b0, bus.YPOS};

  // Classify the incoming pixel against the box and the checkerboard
  always_comb begin
    w_inside  = in_span(w_x, w_box_x, c_BOX_W) && in_span(w_y, w_box_y, c_BOX_H);
    w_border  = w_inside &&
                (near_edge(w_x, w_box_x, c_BOX_W, c_BORDER) ||
                 near_edge(w_y, w_box_y, c_BOX_H, c_BORDER));
    w_checker = bus.XPOS[5] ^ bus.YPOS[5];
  end

  // Stage 1: capture timing and the pixel classification
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      r_s1_hsync   <= 1'b1;
      r_s1_vsync   <= 1'b1;
      r_s1_den     <= 1'b0;
      r_s1_inside  <= 1'b0;
      r_s1_border  <= 1'b0;
      r_s1_checker <= 1'b0;
    end else begin
      r_s1_hsync   <= bus.HSYNC_IN;
      r_s1_vsync   <= bus.VSYNC_IN;
      r_s1_den     <= bus.DEN_IN;
      r_s1_inside  <= w_inside;
      r_s1_border  <= w_border;
      r_s1_checker <= w_checker;
    end
  end

  // Colour priority: blanking, border, fill, checkerboard, black
  always_comb begin
    w_rgb = c_COL_BLACK;
    if (!r_s1_den) begin
      w_rgb = c_COL_BLACK;
    end else if (r_s1_border) begin
      w_rgb = c_COL_WHITE;
    end else if (r_s1_inside) begin
      w_rgb = c_COL_FILL;
    end else if (r_s1_checker) begin
      w_rgb = c_COL_BG_DARK;
    end
  end

  // Stage 2: registered colour and delay-matched timing
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      r_s2_rgb   <= c_COL_BLACK;
      r_s2_hsync <= 1'b1;
      r_s2_vsync <= 1'b1;
      r_s2_den   <= 1'b0;
    end else begin
      r_s2_rgb   <= w_rgb;
      r_s2_hsync <= r_s1_hsync;
      r_s2_vsync <= r_s1_vsync;
      r_s2_den   <= r_s1_den;
    end
  end

  assign bus.HSYNC_OUT  = r_s2_hsync;
  assign bus.VSYNC_OUT  = r_s2_vsync;
  assign bus.DEN_OUT    = r_s2_den;
  assign bus.LCD_R      = r_s2_rgb.r;
  assign bus.LCD_G      = r_s2_rgb.g;
  assign bus.LCD_B      = r_s2_rgb.b;
  assign bus.FRAME_TICK = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_lcd_box_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_box_renderer
// Brief    : Scoreboard bench for the bouncing-box renderer. A behavioural
//            model predicts every output cycle; a monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_box_renderer;
  import lcd_box_renderer_pkg::*;

  localparam int H      = 480;
  localparam int V      = 272;
  localparam int BW     = 64;
  localparam int BH     = 48;
  localparam int STEP   = 1;
  localparam int BORDER = 2;

  // {hsync, vsync, den, r, g, b}
  localparam logic [18:0] c_RST_VAL = {1'b1, 1'b1, 1'b0, 16'h0000};

  typedef struct {
    int          due;
    logic [18:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tick_seen = 0;

  exp_t pix_q[$];
  exp_t tick_q[$];

  // Reference model state
  int   m_bx, m_by, m_vx, m_vy;
  logic m_vprev;

  always #5 clk = ~clk;

  lcd_box_renderer_if bus ();

  lcd_box_renderer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .BOX_W    (BW),
    .BOX_H    (BH),
    .STEP     (STEP),
    .BORDER   (BORDER)
  ) dut (
    .PIXEL_CLK (clk),
    .RESET     (rst),
    .bus       (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Expected colour of one pixel given the box's top-left corner
  function automatic logic [15:0] pixel_colour(input int x, input int y, input logic den,
                                               input int bx, input int by);
    int edge_d;
    if (!den) return 16'h0000;
    if (x >= bx && x < bx + BW && y >= by && y < by + BH) begin
      edge_d = x - bx;
      if (bx + BW - 1 - x < edge_d) edge_d = bx + BW - 1 - x;
      if (y - by < edge_d)          edge_d = y - by;
      if (by + BH - 1 - y < edge_d) edge_d = by + BH - 1 - y;
      return (edge_d < BORDER) ? {5'd31, 6'd63, 5'd31} : {5'd31, 6'd0, 5'd0};
    end
    if ((((x / 32) + (y / 32)) % 2) == 1) return {5'd4, 6'd8, 5'd4};
    return 16'h0000;
  endfunction

  // One axis of travel: move by STEP, clamp to the edge and reverse there
  task automatic bounce(inout int pos, inout int vel, input int span);
    if (vel > 0) begin
      if (pos + STEP > span) begin pos = span; vel = -1; end
      else pos = pos + STEP;
    end else begin
      if (pos - STEP < 0) begin pos = 0; vel = 1; end
      else pos = pos - STEP;
    end
  endtask

  // Apply one cycle of inputs, predict outputs, then advance one clock
  task automatic drive(input logic r, input logic en, input logic hs, input logic vs,
                       input logic den, input int x, input int y);
    logic fs;
    rst          = r;
    bus.ENABLE   = en;
    bus.HSYNC_IN = hs;
    bus.VSYNC_IN = vs;
    bus.DEN_IN   = den;
    bus.XPOS     = 11'(x);
    bus.YPOS     = 11'(y);
    if (r) begin
      if (pix_q.size() > 0 && pix_q[$].due == cyc + 1) void'(pix_q.pop_back());
      pix_q.push_back('{cyc + 1, c_RST_VAL});
      pix_q.push_back('{cyc + 2, c_RST_VAL});
      tick_q.push_back('{cyc + 1, 19'd0});
      m_bx = 0; m_by = 0; m_vx = 1; m_vy = 1;
      m_vprev = 1'b1;
    end else begin
      pix_q.push_back('{cyc + 2, {hs, vs, den, pixel_colour(x, y, den, m_bx, m_by)}});
      fs = m_vprev && !vs;
      tick_q.push_back('{cyc + 1, 19'(fs)});
      if (fs && en) begin
        bounce(m_bx, m_vx, H - BW);
        bounce(m_by, m_vy, V - BH);
      end
      m_vprev = vs;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int centre, input int size, input int lim);
    int v;
    case ($urandom_range(0, 7))
      0:       v = $urandom_range(0, 2047);
      1, 2, 3: v = $urandom_range(0, lim - 1);
      default: v = centre + $urandom_range(0, size + 7) - 4;
    endcase
    if (v < 0) v = 0;
    if (v > 2047) v = 2047;
    return v;
  endfunction

  task automatic rand_pixel(input logic en);
    drive(1'b0, en, ($urandom_range(0, 15) != 0), 1'b1, ($urandom_range(0, 7) != 0),
          pick(m_bx, BW, H), pick(m_by, BH, V));
  endtask

  // VSYNC low for two cycles (one frame start), then a few active pixels
  task automatic frame(input logic en);
    int n;
    drive(1'b0, en, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, en, 1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b0, en, 1'b1, 1'b1, 1'b0, 0, 0);
    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) rand_pixel(en);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_box(input string name, input int wx, input int wy);
    check_int({name, ".x"}, int'(dut.u_axis_x.r_pos), wx);
    check_int({name, ".y"}, int'(dut.u_axis_y.r_pos), wy);
  endtask

  // Monitor: compare every output cycle against the scoreboard
  always @(negedge clk) begin
    exp_t        e;
    logic [18:0] act;
    act = {bus.HSYNC_OUT, bus.VSYNC_OUT, bus.DEN_OUT, bus.LCD_R, bus.LCD_G, bus.LCD_B};
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      e = pix_q.pop_front();
      n_cmp++;
      if (e.due != cyc || act !== e.val) begin
        n_bad++;
        $display("FAIL pixel cyc=%0d due=%0d: got hs/vs/den=%b rgb=%h, want hs/vs/den=%b rgb=%h",
                 cyc, e.due, act[18:16], act[15:0], e.val[18:16], e.val[15:0]);
      end
    end
    while (tick_q.size() > 0 && tick_q[0].due <= cyc) begin
      e = tick_q.pop_front();
      n_cmp++;
      if (e.due != cyc || bus.FRAME_TICK !== e.val[0]) begin
        n_bad++;
        $display("FAIL frame_tick cyc=%0d due=%0d: got %b, want %b",
                 cyc, e.due, bus.FRAME_TICK, e.val[0]);
      end
    end
    if (bus.FRAME_TICK === 1'b1) tick_seen++;
  end

  initial begin
    int t0;
    int nf;

    // Reset for three cycles
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    check_box("reset_box", 0, 0);
    check_int("reset_dir_x", int'(dut.u_axis_x.r_dir), int'(DIR_POS));

    // Directed colours and sync latency
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10, 10);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 100, 10);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 100, 40);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10, 10);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10, 10);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 63, 47);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 62, 20);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 61, 45);
    for (int i = 0; i < 8; i++) rand_pixel(1'b1);

    // Five frames of motion
    t0 = tick_seen;
    for (int i = 0; i < 5; i++) frame(1'b1);
    check_box("motion5", 5, 5);
    check_int("motion5_ticks", tick_seen - t0, 5);
    nf = 5;

    // Run to the bottom edge, then through the one-frame dwell
    while (nf < 224) begin frame(1'b1); nf++; end
    check_box("frame224", 224, 224);
    frame(1'b1); nf++;
    check_box("frame225", 225, 224);
    check_int("frame225_dir_y", int'(dut.u_axis_y.r_dir), int'(DIR_NEG));
    frame(1'b1); nf++;
    check_box("frame226", 226, 223);

    // Run to the right edge
    while (nf < 416) begin frame(1'b1); nf++; end
    check_box("frame416", 416, 33);
    frame(1'b1); nf++;
    check_box("frame417", 416, 32);
    frame(1'b1); nf++;
    check_box("frame418", 415, 31);

    // Motion disabled from (7,7)
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 7; i++) frame(1'b1);
    check_box("pre_hold", 7, 7);
    t0 = tick_seen;
    for (int i = 0; i < 3; i++) frame(1'b0);
    check_box("hold", 7, 7);
    check_int("hold_ticks", tick_seen - t0, 3);

    // Long VSYNC low: a single frame start
    t0 = tick_seen;
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    check_int("long_vsync_ticks", tick_seen - t0, 1);
    check_box("long_vsync_box", 8, 8);

    // Mid-frame reset from (37,37)
    for (int i = 0; i < 29; i++) frame(1'b1);
    check_box("pre_reset", 37, 37);
    for (int i = 0; i < 4; i++) rand_pixel(1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 40, 40);
    check_box("mid_reset", 0, 0);
    check_int("mid_reset_dir_x", int'(dut.u_axis_x.r_dir), int'(DIR_POS));
    check_int("mid_reset_dir_y", int'(dut.u_axis_y.r_dir), int'(DIR_POS));
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, $urandom_range(0, 70), $urandom_range(0, 50));

    // Random enables to finish
    for (int i = 0; i < 20; i++) frame(1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
